argmax_tm: RTL

//  Time-multiplexed arg-max/arg-min over N signed or unsigned operands, using NCMP shared comparators.

---
 rtl/argmax_tm.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/argmax_tm.sv
// argmax_tm: time-multiplexed arg-max / arg-min over N operands using NCMP
// shared comparators. Each REDUCE cycle pairs the head of the candidate list,
// keeps the pair winners in order and appends the unpaired tail, until one
// candidate remains. The list always stays sorted by original index, so the
// first element of a pair wins ties and the lowest index wins overall.
module argmax_tm #(
   parameter int WIDTH = 8,
   parameter int N     = 10,
   parameter int NCMP  = 3,
   parameter int IDX_W = $clog2(N)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data [N],
   input  logic             in_min,
   input  logic             in_signed,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IDX_W-1:0] out_idx,
   output logic [WIDTH-1:0] out_val
);
   localparam int CNT_W = $clog2(N + 1);

   typedef enum logic [1:0] {IDLE, REDUCE, HOLD} state_t;

   generate
      if (N < 2 || NCMP < 1 || NCMP > N / 2) begin : g_bad_params
         $error("argmax_tm: need N >= 2 and 1 <= NCMP <= N/2");
      end
   endgenerate

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   val_q [N];
   logic [WIDTH-1:0]   val_d [N];
   logic [IDX_W-1:0]   idx_q [N];
   logic [IDX_W-1:0]   idx_d [N];
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               min_q, min_d;
   logic               sgn_q, sgn_d;
   logic               out_valid_q, out_valid_d;
   logic [IDX_W-1:0]   out_idx_q, out_idx_d;
   logic [WIDTH-1:0]   out_val_q, out_val_d;

   // round datapath
   logic [CNT_W-1:0]   half, k, cnt_nxt;
   logic [IDX_W:0]     src;
   logic [WIDTH-1:0]   win_val [N];
   logic [IDX_W-1:0]   win_idx [N];
   logic [WIDTH-1:0]   nval [N];
   logic [IDX_W-1:0]   nidx [N];

   // True when a strictly beats b under the captured min/max and sign mode.
   function automatic logic beats(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  input logic mn, input logic sg);
      logic a_lt, b_lt;
      if (sg) begin
         a_lt = $signed(a) < $signed(b);
         b_lt = $signed(b) < $signed(a);
      end else begin
         a_lt = a < b;
         b_lt = b < a;
      end
      return mn ? a_lt : b_lt;
   endfunction

   // One reduction round: k pair compares, winners first, unpaired tail shifted down by k.
   always_comb begin
      half    = cnt_q >> 1;
      k       = (half < CNT_W'(NCMP)) ? half : CNT_W'(NCMP);
      cnt_nxt = cnt_q - k;
      src     = '0;
      for (int j = 0; j < N; j++) begin
         win_val[j] = val_q[j];
         win_idx[j] = idx_q[j];
      end
      for (int j = 0; j < NCMP; j++) begin
         if (beats(val_q[2*j+1], val_q[2*j], min_q, sgn_q)) begin
            win_val[j] = val_q[2*j+1];
            win_idx[j] = idx_q[2*j+1];
         end else begin
            win_val[j] = val_q[2*j];
            win_idx[j] = idx_q[2*j];
         end
      end
      for (int i = 0; i < N; i++) begin
         nval[i] = val_q[i];
         nidx[i] = idx_q[i];
         src     = (IDX_W+1)'(i) + (IDX_W+1)'(k);
         if (CNT_W'(i) < k) begin
            nval[i] = win_val[i];
            nidx[i] = win_idx[i];
         end else if (src < (IDX_W+1)'(N)) begin
            nval[i] = val_q[src[IDX_W-1:0]];
            nidx[i] = idx_q[src[IDX_W-1:0]];
         end
      end
   end

   // FSM next state: capture on accept, reduce each cycle, hold result until taken.
   always_comb begin
      state_d     = state_q;
      val_d       = val_q;
      idx_d       = idx_q;
      cnt_d       = cnt_q;
      min_d       = min_q;
      sgn_d       = sgn_q;
      out_valid_d = out_valid_q;
      out_idx_d   = out_idx_q;
      out_val_d   = out_val_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               state_d = REDUCE;
               val_d   = in_data;
               for (int i = 0; i < N; i++) idx_d[i] = IDX_W'(i);
               cnt_d   = CNT_W'(N);
               min_d   = in_min;
               sgn_d   = in_signed;
            end
         end
         REDUCE: begin
            val_d = nval;
            idx_d = nidx;
            cnt_d = cnt_nxt;
            if (cnt_nxt == CNT_W'(1)) begin
               state_d     = HOLD;
               out_valid_d = 1'b1;
               out_idx_d   = nidx[0];
               out_val_d   = nval[0];
            end
         end
         HOLD: begin
            if (out_ready) begin
               state_d     = IDLE;
               out_valid_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Control and result registers; reset discards any transaction in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         min_q       <= 1'b0;
         sgn_q       <= 1'b0;
         out_valid_q <= 1'b0;
         out_idx_q   <= '0;
         out_val_q   <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         min_q       <= min_d;
         sgn_q       <= sgn_d;
         out_valid_q <= out_valid_d;
         out_idx_q   <= out_idx_d;
         out_val_q   <= out_val_d;
      end
   end

   // Candidate list storage; contents are only meaningful after a capture.
   always_ff @(posedge clk) begin
      val_q <= val_d;
      idx_q <= idx_d;
   end

   // in_ready is held low while reset is asserted and rises as soon as it drops.
   assign in_ready  = (state_q == IDLE) && !reset;
   assign out_valid = out_valid_q;
   assign out_idx   = out_idx_q;
   assign out_val   = out_val_q;
endmodule
